// File: rtl/fb_plot_if.sv
// ----------------------------------------------------------------------------
// fb_plot_if
//   Plot request channel between a drawing controller (master) and the
//   framebuffer plot sink (slave). A request transfers on a rising clock edge
//   where plot_valid && plot_ready.
//
//   plot_valid  master -> slave  request present
//   plot_x      master -> slave  request column
//   plot_y      master -> slave  request row
//   plot_color  master -> slave  request colour
//   plot_ready  slave  -> master sink can accept this cycle
// ----------------------------------------------------------------------------
interface fb_plot_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               plot_valid;
    logic [X_W-1:0]     plot_x;
    logic [Y_W-1:0]     plot_y;
    logic [COLOR_W-1:0] plot_color;
    logic               plot_ready;

    modport master (
        output plot_valid, plot_x, plot_y, plot_color,
        input  plot_ready
    );

    modport slave (
        input  plot_valid, plot_x, plot_y, plot_color,
        output plot_ready
    );
endinterface

// File: rtl/fb_plot_sink.sv
// ----------------------------------------------------------------------------
// fb_plot_sink
//   Responder end of the plot channel. Accepted plot requests are converted
//   to linear framebuffer addresses and queued in a small FIFO, which drains
//   one registered framebuffer write per cycle. A clear request flushes the
//   queue and sweeps the whole screen with a fill colour. A free-running
//   counter produces the periodic scroll_tick pulse.
//
//   Optional feature macro: FB_CLIP_EN
//     defined   : off-screen requests are handshaken but discarded and
//                 counted on drop_count (saturating at 255).
//     undefined : no range check; drop_count port absent.
//
// Ports
//   clk          clock, rising edge
//   resetn       synchronous active-low reset
//   plot         fb_plot_if.slave (valid/x/y/colour in, ready out)
//   clear_req    start a full-screen clear (level-sensitive, sampled in IDLE)
//   clear_color  fill colour, captured on the clear start edge
//   busy         clear sweep in progress
//   fb_we        framebuffer write strobe (registered)
//   fb_addr      y*SCREEN_W + x (registered)
//   fb_data      write colour (registered)
//   scroll_tick  one-cycle pulse every TICK_CYCLES cycles
//   drop_count   discarded off-screen requests (FB_CLIP_EN only)
// ----------------------------------------------------------------------------
module fb_plot_sink #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOR_W     = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int ADDR_W      = 15,
    parameter int FIFO_DEPTH  = 4,
    parameter int TICK_CYCLES = 833333
) (
    input  logic               clk,
    input  logic               resetn,
    fb_plot_if.slave           plot,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               busy,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               scroll_tick
`ifdef FB_CLIP_EN
    ,
    output logic [7:0]         drop_count
`endif
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TICK_W  = $clog2(TICK_CYCLES);
    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic [0:0]         state;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               fifo_full, fifo_empty;
    logic               accept, push, pop;
    logic [ADDR_W-1:0]  plot_addr;
    logic [ADDR_W-1:0]  sweep_addr;
    logic [COLOR_W-1:0] fill_color;
    logic [TICK_W-1:0]  tick_cnt;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = (state == S_CLEAR);

    // Ready depends on registered state only, so a drawing controller never
    // sees a combinational path from its own valid back into ready.
    assign plot.plot_ready = !fifo_full && (state == S_IDLE);
    assign accept          = plot.plot_valid && plot.plot_ready;

    // Address is formed at full ADDR_W width before the multiply so valid
    // coordinates never lose high bits; out-of-range ones wrap naturally.
    assign plot_addr = ADDR_W'(plot.plot_y) * ADDR_W'(SCREEN_W) + ADDR_W'(plot.plot_x);

`ifdef FB_CLIP_EN
    logic in_range;
    assign in_range = (32'(plot.plot_x) < SCREEN_W) && (32'(plot.plot_y) < SCREEN_H);
    // A clear on the same edge wins: the request is neither queued nor counted.
    assign push = accept && !clear_req && in_range;
`else
    assign push = accept && !clear_req;
`endif

    assign pop = (state == S_IDLE) && !clear_req && !fifo_empty;

    // NOTE: the FIFO storage has no reset; pointers and count define which
    // entries are valid, so resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {plot_addr, plot.plot_color};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sweep_addr <= '0;
            fill_color <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
        end else begin
            fb_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        // Flush pending plots and start the sweep at address 0.
                        state      <= S_CLEAR;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        count      <= '0;
                        sweep_addr <= '0;
                        fill_color <= clear_color;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                        if (pop) begin
                            rd_ptr             <= rd_ptr + PTR_W'(1);
                            fb_we              <= 1'b1;
                            {fb_addr, fb_data} <= fifo_mem[rd_ptr];
                        end
                        case ({push, pop})
                            2'b10:   count <= count + (PTR_W+1)'(1);
                            2'b01:   count <= count - (PTR_W+1)'(1);
                            default: count <= count;
                        endcase
                    end
                end
                default: begin
                    fb_we      <= 1'b1;
                    fb_addr    <= sweep_addr;
                    fb_data    <= fill_color;
                    sweep_addr <= sweep_addr + ADDR_W'(1);
                    if (sweep_addr == LAST_ADDR) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Free-running tick; the pulse is registered in the cycle after the
    // counter reaches its last value, so the first pulse lands TICK_CYCLES
    // cycles after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_cnt    <= '0;
            scroll_tick <= 1'b0;
        end else begin
            scroll_tick <= (tick_cnt == TICK_LAST);
            tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
        end
    end

`ifdef FB_CLIP_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (accept && !clear_req && !in_range && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fb_plot_sink.sv
// ----------------------------------------------------------------------------
// tb_fb_plot_sink
//   Self-checking bench for fb_plot_sink. A behavioural model (queue of
//   pending writes, remaining sweep length, cycles since reset release)
//   predicts ready/busy before every edge and the write strobe, address,
//   data and scroll_tick after it. Directed steps cover single plots,
//   streaming, clear with queued plots, tick timing, off-screen coordinates
//   and reset during a clear; a randomized burst exercises the plot path.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_plot_sink;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    localparam int COLOR_W     = 3;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;
    localparam int ADDR_W      = 15;
    localparam int FIFO_DEPTH  = 4;
    localparam int TICK_CYCLES = 8;
    localparam int NPIX        = SCREEN_W * SCREEN_H;

    logic               clk = 1'b0;
    logic               resetn;
    logic               clear_req;
    logic [COLOR_W-1:0] clear_color;
    logic               busy;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               scroll_tick;
`ifdef FB_CLIP_EN
    logic [7:0]         drop_count;
`endif

    always #5 clk = ~clk;

    fb_plot_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) plot_if ();

    fb_plot_sink #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .TICK_CYCLES(TICK_CYCLES)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .plot(plot_if),
        .clear_req(clear_req),
        .clear_color(clear_color),
        .busy(busy),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .scroll_tick(scroll_tick)
`ifdef FB_CLIP_EN
        ,
        .drop_count(drop_count)
`endif
    );

    typedef struct {
        int addr;
        int color;
    } wr_t;

    // Reference model state
    wr_t pend[$];
    int  clr_left, clr_addr, clr_color_m, rel_cyc, drops_m;
    bit  armed;

    // Observation counters
    int          n_assert, n_fail;
    int          n_we, n_busy, n_tick;
    logic [31:0] last_addr, last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict from the model, step the edge, compare.
    task automatic cycle();
        bit  rst_now, exp_ready, exp_we, acc;
        wr_t w;
        int  x, y;
        w.addr    = 0;
        w.color   = 0;
        rst_now   = !resetn;
        exp_ready = (clr_left == 0) && (pend.size() < FIFO_DEPTH);
        if (armed) begin
            check("plot_ready", 32'(plot_if.plot_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(clr_left > 0));
        end
        acc    = plot_if.plot_valid && exp_ready;
        exp_we = 1'b0;
        if (rst_now) begin
            pend.delete();
            clr_left = 0;
            rel_cyc  = 0;
            drops_m  = 0;
        end else begin
            rel_cyc++;
            if (clr_left > 0) begin
                exp_we  = 1'b1;
                w.addr  = clr_addr;
                w.color = clr_color_m;
                clr_addr++;
                clr_left--;
            end else if (clear_req) begin
                pend.delete();
                clr_left    = NPIX;
                clr_addr    = 0;
                clr_color_m = int'(clear_color);
            end else begin
                if (pend.size() > 0) begin
                    exp_we = 1'b1;
                    w      = pend.pop_front();
                end
                if (acc) begin
                    x = int'(plot_if.plot_x);
                    y = int'(plot_if.plot_y);
`ifdef FB_CLIP_EN
                    if (x >= SCREEN_W || y >= SCREEN_H) begin
                        if (drops_m < 255) drops_m++;
                    end else begin
                        pend.push_back('{addr: y * SCREEN_W + x, color: int'(plot_if.plot_color)});
                    end
`else
                    pend.push_back('{addr: (y * SCREEN_W + x) % (1 << ADDR_W),
                                     color: int'(plot_if.plot_color)});
`endif
                end
            end
        end

        @(posedge clk);
        #1;

        if (armed || rst_now) begin
            check("fb_we", 32'(fb_we), 32'(exp_we));
            if (exp_we) begin
                check("fb_addr", 32'(fb_addr), w.addr);
                check("fb_data", 32'(fb_data), w.color);
            end
            if (rst_now) begin
                check("fb_addr_rst", 32'(fb_addr), 0);
                check("fb_data_rst", 32'(fb_data), 0);
            end
            check("scroll_tick", 32'(scroll_tick),
                  32'(!rst_now && (rel_cyc % TICK_CYCLES == 0)));
`ifdef FB_CLIP_EN
            check("drop_count", 32'(drop_count), drops_m);
`endif
        end
        if (rst_now) armed = 1'b1;
        if (fb_we === 1'b1) begin
            n_we++;
            last_addr = 32'(fb_addr);
            last_data = 32'(fb_data);
        end
        if (busy === 1'b1) n_busy++;
        if (scroll_tick === 1'b1) n_tick++;
    endtask

    task automatic idle(input int n);
        plot_if.plot_valid = 1'b0;
        clear_req          = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        plot_if.plot_x     = X_W'(x);
        plot_if.plot_y     = Y_W'(y);
        plot_if.plot_color = COLOR_W'(c);
    endtask

    task automatic plot_once(input int x, input int y, input int c);
        plot_if.plot_valid = 1'b1;
        set_plot(x, y, c);
        cycle();
        plot_if.plot_valid = 1'b0;
    endtask

    initial begin
        int n0, b0, t0;
        n_assert = 0; n_fail = 0;
        n_we = 0; n_busy = 0; n_tick = 0;
        last_addr = '0; last_data = '0;
        clr_left = 0; clr_addr = 0; clr_color_m = 0; rel_cyc = 0; drops_m = 0;
        armed = 1'b0;
        resetn = 1'b0;
        clear_req = 1'b0;
        clear_color = '0;
        plot_if.plot_valid = 1'b0;
        set_plot(0, 0, 0);

        // Reset, then tick pulses at 8, 16, 24 after release.
        cycle();
        cycle();
        resetn = 1'b1;
        t0 = n_tick;
        idle(25);
        check("tick_first_three", n_tick - t0, 3);

        // Reset asserted on cycle 20 after release; next pulse 8 after release.
        resetn = 1'b0; cycle(); resetn = 1'b1;
        idle(19);
        resetn = 1'b0; cycle(); resetn = 1'b1;
        t0 = n_tick;
        idle(7);
        check("tick_after_rst_early", n_tick - t0, 0);
        idle(1);
        check("tick_after_rst", 32'(scroll_tick), 1);

        // Single plot: exactly one write at 3 + 2*160.
        n0 = n_we;
        plot_once(3, 2, 5);
        idle(3);
        check("single_writes", n_we - n0, 1);
        check("single_addr", last_addr, 323);
        check("single_data", last_data, 5);

        // Six distinct back-to-back plots with valid held high.
        n0 = n_we;
        plot_if.plot_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_plot(i * 20 + int'($urandom_range(0, 19)), int'($urandom_range(0, 119)),
                     int'($urandom_range(0, 7)));
            cycle();
        end
        idle(3);
        check("stream_writes", n_we - n0, 6);

        // Random plot traffic.
        for (int i = 0; i < 300; i++) begin
            plot_if.plot_valid = 1'($urandom_range(0, 1));
            set_plot(int'($urandom_range(0, SCREEN_W - 1)), int'($urandom_range(0, SCREEN_H - 1)),
                     int'($urandom_range(0, 7)));
            cycle();
        end
        idle(3);

        // Off-screen coordinates.
        n0 = n_we;
        plot_once(160, 0, 1);
        idle(2);
`ifdef FB_CLIP_EN
        check("clip_x_dropped", n_we - n0, 0);
`else
        check("noclip_addr160", last_addr, 160);
`endif
        plot_once(0, 120, 2);
        idle(2);
        plot_once(159, 119, 3);
        idle(2);
        check("edge_addr", last_addr, 19199);
`ifdef FB_CLIP_EN
        check("clip_writes", n_we - n0, 1);
        check("clip_drop_count", 32'(drop_count), 2);
`else
        check("noclip_writes", n_we - n0, 3);
`endif

        // Clear with plots queued and a same-edge plot offered.
        plot_if.plot_valid = 1'b1;
        set_plot(10, 10, 7); cycle();
        set_plot(11, 10, 7); cycle();
        n0 = n_we;
        b0 = n_busy;
        set_plot(12, 10, 7);
        clear_req   = 1'b1;
        clear_color = 3'd2;
        cycle();
        clear_color = 3'd6;
        idle(NPIX + 5);
        check("clear_writes", n_we - n0, NPIX);
        check("clear_busy_cycles", n_busy - b0, NPIX);
        check("clear_last_addr", last_addr, NPIX - 1);
        check("clear_last_data", last_data, 2);

        // Reset in the middle of a clear at sweep address 500.
        clear_req   = 1'b1;
        clear_color = COLOR_W'($urandom_range(0, 7));
        cycle();
        clear_req = 1'b0;
        idle(500);
        check("midclear_last_sweep", last_addr, 499);
        n0 = n_we;
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        check("midclear_busy", 32'(busy), 0);
        check("midclear_ready", 32'(plot_if.plot_ready), 1);
        idle(20);
        check("midclear_no_writes", n_we - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
